// File: rtl/tm_asm_rand.sv
// CADU builder: buffers RS codeblock bytes, prefixes each codeblock with the ASM and
// randomizes data bytes when TM_RAND_EN is defined (pass-through otherwise).
module tm_asm_rand #(
   parameter int          CBLEN   = 255,
   parameter int          FIFO_AW = 4,
   parameter logic [31:0] ASM     = 32'h1ACFFC1D
) (
   input  logic       CLK,
   input  logic       NGRST,
   input  logic       CLKEN,
   input  logic       CLR,
   input  logic [7:0] DIN,
   input  logic       DIN_VLD,
   output logic [7:0] DOUT,
   output logic       DVALID,
   input  logic       DREADY,
   output logic       FSTART,
   output logic       OVF
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = 10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ASM  = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       asm_idx_q, asm_idx_d;
   logic [FIFO_AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [7:0]       dout_q, dout_d;
   logic             dvalid_q, dvalid_d;
   logic             fstart_q, fstart_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       mem_q [DEPTH];

   logic             full_s, empty_s, out_free_s, wr_req_s, push_s, pop_s;
   logic [7:0]       rd_byte_s, rand_s;

   function automatic logic [7:0] asm_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return ASM[31:24];
         2'd1:    return ASM[23:16];
         2'd2:    return ASM[15:8];
         2'd3:    return ASM[7:0];
         default: return 8'h00;
      endcase
   endfunction

   // Extra pointer MSB distinguishes full from empty when the address bits match
   assign full_s     = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                       (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
   assign empty_s    = (wptr_q == rptr_q);
   assign out_free_s = !dvalid_q || DREADY;
   assign wr_req_s   = CLKEN && DIN_VLD;
   assign push_s     = wr_req_s && (!full_s || pop_s);
   assign rd_byte_s  = mem_q[rptr_q[FIFO_AW-1:0]];

`ifdef TM_RAND_EN
   logic [7:0] lfsr_q, lfsr_d;

   // Holds the next 8 sequence bits, oldest in bit 7; steps h(x)=x^8+x^7+x^5+x^3+1 by a byte
   function automatic logic [7:0] lfsr_next8(input logic [7:0] s);
      logic [15:0] b;
      logic [7:0]  r;
      b = 16'h0000;
      r = 8'h00;
      for (int i = 0; i < 8; i++) b[i] = s[7-i];
      for (int i = 8; i < 16; i++) b[i] = b[i-1] ^ b[i-3] ^ b[i-5] ^ b[i-8];
      for (int i = 0; i < 8; i++) r[7-i] = b[i+8];
      return r;
   endfunction

   // Randomizer next state
   always_comb begin
      lfsr_d = lfsr_q;
      if (CLR) begin
         lfsr_d = 8'hFF;
      end else if (state_q == S_IDLE && out_free_s && !empty_s) begin
         lfsr_d = 8'hFF;
      end else if (pop_s) begin
         lfsr_d = lfsr_next8(lfsr_q);
      end else begin
         lfsr_d = lfsr_q;
      end
   end

   // Randomizer register
   always_ff @(posedge CLK or negedge NGRST) begin
      if (!NGRST) lfsr_q <= 8'hFF;
      else        lfsr_q <= lfsr_d;
   end

   assign rand_s = lfsr_q;
`else
   assign rand_s = 8'h00;
`endif

   // Read-side FSM and output register next state; registers only move when the slot is free
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      asm_idx_d = asm_idx_q;
      dout_d    = dout_q;
      dvalid_d  = dvalid_q;
      fstart_d  = fstart_q;
      pop_s     = 1'b0;
      if (CLR) begin
         state_d   = S_IDLE;
         cnt_d     = {CW{1'b0}};
         asm_idx_d = 2'd0;
         dout_d    = 8'h00;
         dvalid_d  = 1'b0;
         fstart_d  = 1'b0;
      end else if (out_free_s) begin
         case (state_q)
            S_IDLE: begin
               if (!empty_s) begin
                  dout_d    = asm_byte(2'd0);
                  dvalid_d  = 1'b1;
                  fstart_d  = 1'b1;
                  asm_idx_d = 2'd1;
                  cnt_d     = {CW{1'b0}};
                  state_d   = S_ASM;
               end else begin
                  dvalid_d = 1'b0;
                  fstart_d = 1'b0;
               end
            end
            S_ASM: begin
               dout_d    = asm_byte(asm_idx_q);
               dvalid_d  = 1'b1;
               fstart_d  = 1'b0;
               asm_idx_d = asm_idx_q + 2'd1;
               if (asm_idx_q == 2'd3) state_d = S_DATA;
               else                   state_d = S_ASM;
            end
            S_DATA: begin
               if (!empty_s) begin
                  pop_s    = 1'b1;
                  dout_d   = rd_byte_s ^ rand_s;
                  dvalid_d = 1'b1;
                  fstart_d = 1'b0;
                  if (cnt_q == CW'(CBLEN - 1)) begin
                     cnt_d   = {CW{1'b0}};
                     state_d = S_IDLE;
                  end else begin
                     cnt_d   = cnt_q + CW'(1);
                     state_d = S_DATA;
                  end
               end else begin
                  dvalid_d = 1'b0;
                  fstart_d = 1'b0;
               end
            end
            default: begin
               state_d  = S_IDLE;
               dvalid_d = 1'b0;
               fstart_d = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // FIFO pointers and sticky overflow; a same-cycle pop makes room for a push into a full FIFO
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      ovf_d  = ovf_q;
      if (CLR) begin
         wptr_d = {(FIFO_AW+1){1'b0}};
         rptr_d = {(FIFO_AW+1){1'b0}};
         ovf_d  = 1'b0;
      end else begin
         wptr_d = wptr_q + {{FIFO_AW{1'b0}}, push_s};
         rptr_d = rptr_q + {{FIFO_AW{1'b0}}, pop_s};
         ovf_d  = ovf_q | (wr_req_s & full_s & ~pop_s);
      end
   end

   // FIFO storage
   always_ff @(posedge CLK) begin
      if (push_s) mem_q[wptr_q[FIFO_AW-1:0]] <= DIN;
   end

   // State, pointer and output registers
   always_ff @(posedge CLK or negedge NGRST) begin
      if (!NGRST) begin
         state_q   <= S_IDLE;
         cnt_q     <= {CW{1'b0}};
         asm_idx_q <= 2'd0;
         wptr_q    <= {(FIFO_AW+1){1'b0}};
         rptr_q    <= {(FIFO_AW+1){1'b0}};
         dout_q    <= 8'h00;
         dvalid_q  <= 1'b0;
         fstart_q  <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         asm_idx_q <= asm_idx_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         dout_q    <= dout_d;
         dvalid_q  <= dvalid_d;
         fstart_q  <= fstart_d;
         ovf_q     <= ovf_d;
      end
   end

   assign DOUT   = dout_q;
   assign DVALID = dvalid_q;
   assign FSTART = fstart_q;
   assign OVF    = ovf_q;

endmodule

// File: tb/tb_tm_asm_rand.sv
// Bench for tm_asm_rand: directed phases with random data/backpressure, scored against a
// frame-level model of the CADU stream (honours TM_RAND_EN like the design).
module tb_tm_asm_rand;
   localparam int CBLEN   = 255;
   localparam int FIFO_AW = 4;
   localparam int CL      = CBLEN + 4;

   logic       CLK = 1'b0;
   logic       NGRST, CLKEN, CLR, DIN_VLD, DREADY;
   logic [7:0] DIN;
   logic [7:0] DOUT;
   logic       DVALID, FSTART, OVF;

   tm_asm_rand #(.CBLEN(CBLEN), .FIFO_AW(FIFO_AW), .ASM(32'h1ACFFC1D)) dut (
      .CLK(CLK), .NGRST(NGRST), .CLKEN(CLKEN), .CLR(CLR), .DIN(DIN), .DIN_VLD(DIN_VLD),
      .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .FSTART(FSTART), .OVF(OVF)
   );

   always #5 CLK = ~CLK;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] in_q[$];
   int         out_idx = 0;
   bit         rec_push = 1'b1;
   bit         rand_ready = 1'b0;
   logic [7:0] cap [9];
   logic [7:0] rnd [CBLEN];
   bit         seq_bits [8*CBLEN];
   logic [7:0] asm_b [4] = '{8'h1A, 8'hCF, 8'hFC, 8'h1D};
   logic [7:0] head_tbl [9];
   bit         gap_mon = 1'b0;
   bit         gap_started = 1'b0;
   int         gap_cnt = 0;
   int         gap_target = 0;
   int         pushed;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected n-th accepted output byte; 9'h100 means the model has no such byte
   function automatic logic [8:0] exp_byte(input int idx);
      int f, p, j;
      f = idx / CL;
      p = idx % CL;
      if (p < 4) return {1'b0, asm_b[p]};
      j = f * CBLEN + p - 4;
      if (j >= in_q.size()) return 9'h100;
      return {1'b0, in_q[j] ^ rnd[p-4]};
   endfunction

   task automatic model_reset();
      in_q.delete();
      out_idx = 0;
      for (int i = 0; i < 9; i++) cap[i] = 8'h00;
   endtask

   task automatic tick();
      logic       xfer, stall;
      logic [7:0] held;
      logic [8:0] e;
      xfer  = DVALID && DREADY && NGRST && !CLR;
      stall = DVALID && !DREADY && NGRST && !CLR;
      held  = DOUT;
      if (xfer) begin
         e = exp_byte(out_idx);
         chk("dout", {24'h0, DOUT}, {23'h0, e});
         chk("fstart", {31'h0, FSTART}, {31'h0, ((out_idx % CL) == 0)});
         if (out_idx < 9) cap[out_idx] = DOUT;
         out_idx++;
      end
      if (CLKEN && DIN_VLD && rec_push && NGRST && !CLR) in_q.push_back(DIN);
      @(posedge CLK);
      #1;
      if (stall) begin
         chk("stall_hold", {24'h0, DOUT}, {24'h0, held});
         chk("stall_valid", {31'h0, DVALID}, 32'h1);
      end
      if (!DVALID) chk("fstart_idle", {31'h0, FSTART}, 32'h0);
      if (gap_mon && out_idx < gap_target) begin
         if (DVALID) gap_started = 1'b1;
         else if (gap_started) gap_cnt++;
      end
   endtask

   task automatic drain(input int target, input int budget);
      DIN_VLD = 1'b0;
      for (int c = 0; c < budget && out_idx < target; c++) begin
         if (rand_ready) DREADY = 1'($urandom_range(0, 1));
         tick();
      end
      chk("drain_count", out_idx, target);
   endtask

   initial begin
      for (int i = 0; i < 8*CBLEN; i++)
         seq_bits[i] = (i < 8) ? 1'b1
                     : seq_bits[i-8] ^ seq_bits[i-5] ^ seq_bits[i-3] ^ seq_bits[i-1];
      for (int k = 0; k < CBLEN; k++) begin
         rnd[k] = 8'h00;
`ifdef TM_RAND_EN
         for (int b = 0; b < 8; b++) rnd[k][7-b] = seq_bits[8*k+b];
`endif
      end
`ifdef TM_RAND_EN
      head_tbl = '{8'h1A, 8'hCF, 8'hFC, 8'h1D, 8'hFF, 8'h49, 8'h0C, 8'hC3, 8'h9E};
`else
      head_tbl = '{8'h1A, 8'hCF, 8'hFC, 8'h1D, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
`endif
      model_reset();

      // Reset values
      NGRST = 1'b0; CLKEN = 1'b1; CLR = 1'b0; DIN_VLD = 1'b0; DIN = 8'h00; DREADY = 1'b1;
      repeat (3) tick();
      chk("rst_dout", {24'h0, DOUT}, 32'h0);
      chk("rst_dvalid", {31'h0, DVALID}, 32'h0);
      chk("rst_fstart", {31'h0, FSTART}, 32'h0);
      chk("rst_ovf", {31'h0, OVF}, 32'h0);
      NGRST = 1'b1;
      tick();

      // Basic CADU with bytes 0x00..0xFE, latency checks on the way
      for (int i = 0; i < CBLEN; i++) begin
         DIN_VLD = 1'b1; DIN = 8'(i);
         tick();
         if (i == 0) chk("lat_n", {31'h0, DVALID}, 32'h0);
         if (i == 1) begin
            chk("lat_n1_valid", {31'h0, DVALID}, 32'h1);
            chk("lat_n1_dout", {24'h0, DOUT}, 32'h1A);
            chk("lat_n1_fstart", {31'h0, FSTART}, 32'h1);
         end
         if (i == 5) chk("lat_n5_data", {24'h0, DOUT}, {24'h0, head_tbl[4]});
      end
      drain(CL, 400);
      for (int i = 0; i < 9; i++) chk("head", {24'h0, cap[i]}, {24'h0, head_tbl[i]});

      // Back-to-back frames at full rate: no output gap, no overflow
      gap_target = out_idx + 2*CL; gap_started = 1'b0; gap_cnt = 0; gap_mon = 1'b1;
      for (int i = 0; i < 2*CBLEN; i++) begin
         DIN_VLD = 1'b1; DIN = 8'($urandom);
         tick();
      end
      drain(gap_target, 100);
      gap_mon = 1'b0;
      chk("b2b_gap", gap_cnt, 0);
      chk("b2b_ovf", {31'h0, OVF}, 32'h0);

      // Random backpressure and input clock enable
      pushed = 0;
      for (int c = 0; c < 8000 && pushed < 2*CBLEN; c++) begin
         CLKEN   = 1'($urandom_range(0, 1));
         DIN_VLD = ($urandom_range(0, 3) == 0);
         DIN     = 8'($urandom);
         DREADY  = 1'($urandom_range(0, 1));
         if (CLKEN && DIN_VLD) pushed++;
         tick();
      end
      CLKEN = 1'b1;
      rand_ready = 1'b1;
      drain(5*CL, 3000);
      rand_ready = 1'b0;
      chk("bp_ovf", {31'h0, OVF}, 32'h0);

      // Asynchronous reset mid-CADU
      DREADY = 1'b1;
      for (int i = 0; i < 40; i++) begin
         DIN_VLD = 1'b1; DIN = 8'($urandom);
         tick();
      end
      NGRST = 1'b0;
      #1;
      chk("arst_dvalid", {31'h0, DVALID}, 32'h0);
      chk("arst_dout", {24'h0, DOUT}, 32'h0);
      chk("arst_fstart", {31'h0, FSTART}, 32'h0);
      model_reset();
      DIN_VLD = 1'b0;
      repeat (2) tick();
      NGRST = 1'b1;
      for (int i = 0; i < CBLEN; i++) begin
         DIN_VLD = 1'b1; DIN = 8'($urandom);
         tick();
      end
      drain(CL, 100);
      chk("arst_first", {24'h0, cap[0]}, 32'h1A);

      // Overflow: 20 pushes into a stalled 16-deep FIFO
      model_reset();
      DREADY = 1'b0;
      for (int i = 0; i < 20; i++) begin
         DIN_VLD = 1'b1; DIN = 8'($urandom);
         rec_push = (i < 16);
         tick();
         if (i == 15) chk("ovf_at16", {31'h0, OVF}, 32'h0);
      end
      rec_push = 1'b1;
      chk("ovf_set", {31'h0, OVF}, 32'h1);
      DREADY = 1'b1;
      drain(20, 100);
      repeat (3) begin
         tick();
         chk("ovf_nomore", {31'h0, DVALID}, 32'h0);
      end
      chk("ovf_sticky", {31'h0, OVF}, 32'h1);

      // CLR abandons a loaded byte and clears OVF
      DREADY = 1'b0; DIN_VLD = 1'b1; DIN = 8'h5A;
      tick();
      DIN_VLD = 1'b0;
      tick();
      chk("pre_clr_valid", {31'h0, DVALID}, 32'h1);
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      chk("clr_dvalid", {31'h0, DVALID}, 32'h0);
      chk("clr_ovf", {31'h0, OVF}, 32'h0);
      chk("clr_dout", {24'h0, DOUT}, 32'h0);
      chk("clr_fstart", {31'h0, FSTART}, 32'h0);
      model_reset();
      DREADY = 1'b1;
      for (int i = 0; i < 5; i++) begin
         DIN_VLD = 1'b1; DIN = 8'($urandom);
         tick();
      end
      drain(9, 50);
      chk("clr_first", {24'h0, cap[0]}, 32'h1A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
